mac_acc: RTL and testbench
==========================

Name: mac_acc

Overview:
- Parametrised, signed, pipelined multiply-accumulate engine for the FIR datapath.
- Multiplies one sample by one coefficient per accepted beat and accumulates exactly N_TAPS products into one output sample.
- Rescales the sum by an arithmetic right shift, saturates it to the output width, and emits a one-cycle out_valid pulse with an overflow flag.
- Sits between the tap/coefficient sequencer and the output register stage; in_valid gaps are tolerated.

Parameters:
- WIDTH_DATA, 8, sample width (signed two's complement)
- WIDTH_COEF, 8, coefficient width (signed)
- N_TAPS, 16, products per output sample (>=2)
- WIDTH_ACC, WIDTH_DATA+WIDTH_COEF+$clog2(N_TAPS), accumulator width
- WIDTH_MAC_OUT, 8, output width (signed)
- SHIFT_OUT, 7, arithmetic right shift applied to the sum before saturation (0..WIDTH_ACC-1)

Ports:
- clk, input, 1, rising-edge clock
- reset, input, 1, synchronous active-low reset (0 = reset)
- in_valid, input, 1, a/b valid this cycle
- in_first, input, 1, qualified by in_valid; beat is tap 0 of a new sample
- a, input, WIDTH_DATA, signed sample
- b, input, WIDTH_COEF, signed coefficient
- dataout, output, WIDTH_MAC_OUT, scaled, saturated sum
- out_valid, output, 1, one-cycle pulse, dataout new
- out_ovf, output, 1, dataout was saturated (valid with out_valid)
- busy, output, 1, accumulation in progress (state ACC)

Behaviour:
- Clock and reset: one clock (clk). Synchronous active-low reset; sampled only on the clk edge.
- Reset values: dataout=0, out_valid=0, out_ovf=0, busy=0; pipeline valid bits=0, acc=0, tap_cnt=0, state=IDLE.
- Reset mid-operation: the partial sum is discarded and no out_valid is produced.
- Stage 1 (product): registers p_r = a*b sign-extended to WIDTH_ACC, plus v_r=in_valid and f_r=in_first.
- Stage 2 (accumulate), acts only when v_r=1; a cycle with v_r=0 holds all state.
- FSM states and transitions:
  - IDLE: on v_r: acc<=p_r, tap_cnt<=1, go to ACC. in_first is not required in IDLE.
  - ACC, v_r && f_r: abort the partial sum, acc<=p_r, tap_cnt<=1, no output.
  - ACC, v_r && tap_cnt==N_TAPS-1: final sum s=acc+p_r; register the output; go to IDLE; acc<=0; tap_cnt<=0.
  - ACC, other v_r: acc<=acc+p_r, tap_cnt++.
- Output stage:
  - Compute y = s >>> SHIFT_OUT (arithmetic).
  - If y > 2^(W-1)-1, dataout=max and out_ovf=1; if y < -2^(W-1), dataout=min and out_ovf=1; otherwise dataout=y[W-1:0] and out_ovf=0 (W=WIDTH_MAC_OUT).
  - out_valid=1 for exactly one cycle. dataout and out_ovf hold until the next output.
- Latency: last beat accepted at edge t -> out_valid high after edge t+2.
- Throughput: one beat per cycle; back-to-back samples with no idle cycle are required to work.
- Accumulator arithmetic: wraps two's complement. No internal overflow is possible at the default WIDTH_ACC, including the full-scale -128*-128 case.
- in_first asserted together with the last beat: treated as an abort and restart, not a completion.

Optional Feature:
- Macro: MAC_ROUND_EN.
- Defined: round half up before the shift, y = (s + 2^(SHIFT_OUT-1)) >>> SHIFT_OUT. The adder is one bit wider than WIDTH_ACC so the rounding add cannot wrap.
- Undefined: truncation, i.e. floor via arithmetic shift.
- SHIFT_OUT==0: no rounding in either case.

Decomposition:
- Shared package fir_pkg:
  - state enum (IDLE, ACC)
  - function sat_shift(value, shift, width) returning {ovf, data}
  - default width constants WIDTH_DATA_DEF, WIDTH_COEF_DEF
- One natural sub-module, mac_sat: the combinational shift/round/saturate block, reused by later FIR output stages.

Test Plan:
- N_TAPS=4, SHIFT_OUT=0: four beats a=3, b=5, first on beat 0 -> dataout=60, out_ovf=0, out_valid exactly 2 cycles after the last beat.
- Defaults (N_TAPS=16, SHIFT_OUT=7): 16 beats a=127, b=127 -> sum 258064, y=2016 -> dataout=127, out_ovf=1. Then 16 beats a=-128, b=127 -> dataout=-128, out_ovf=1.
- N_TAPS=4, SHIFT_OUT=1: products summing to 3 -> 1 without MAC_ROUND_EN, 2 with it. Products summing to -3 -> -2 without it, -1 with it.
- N_TAPS=4: 2 beats, then in_first with 4 beats of a=1, b=1 -> a single out_valid with dataout=4 (aborted partial sum ignored).
- N_TAPS=4: 3 beats accepted, then reset=0 for one cycle, then 4 new beats -> no spurious out_valid; a single correct result. in_valid gaps of 1-3 cycles inserted -> same result as the gapless run.
- N_TAPS=4: 12 consecutive beats, three samples back-to-back -> three out_valid pulses spaced 4 cycles apart with the correct values.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR datapath types: accumulator FSM states and the shift/saturate helper
// used by every stage that narrows a wide sum to an output sample.
package fir_pkg;

    localparam int WIDTH_DATA_DEF = 8;
    localparam int WIDTH_COEF_DEF = 8;
    localparam int SAT_W          = 64;

    typedef enum logic {IDLE, ACC} state_t;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] data;
    } sat_t;

    // Arithmetic shift right, then clamp to a signed 'width'-bit range.
    function automatic sat_t sat_shift(input logic signed [SAT_W-1:0] value,
                                       input int shift, input int width);
        logic signed [SAT_W-1:0] y;
        logic signed [SAT_W-1:0] mx;
        sat_t r;
        y     = value >>> shift;
        mx    = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
        r.ovf = 1'b1;
        if (y > mx)       r.data = mx;
        else if (y < ~mx) r.data = ~mx;
        else begin
            r.data = y;
            r.ovf  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_acc_if.sv
// Beat/result bundle between the tap sequencer, the MAC engine and the output register.
interface mac_acc_if
    import fir_pkg::*;
#(
    parameter int WIDTH_DATA    = WIDTH_DATA_DEF,
    parameter int WIDTH_COEF    = WIDTH_COEF_DEF,
    parameter int WIDTH_MAC_OUT = 8
);
    logic                            in_valid;
    logic                            in_first;
    logic signed [WIDTH_DATA-1:0]    a;
    logic signed [WIDTH_COEF-1:0]    b;
    logic signed [WIDTH_MAC_OUT-1:0] dataout;
    logic                            out_valid;
    logic                            out_ovf;
    logic                            busy;

    modport master (output in_valid, in_first, a, b,
                    input  dataout, out_valid, out_ovf, busy);
    modport slave  (input  in_valid, in_first, a, b,
                    output dataout, out_valid, out_ovf, busy);
endinterface

// File: rtl/mac_sat.sv
// Combinational shift/round/saturate of a wide signed sum to WIDTH_OUT bits.
// MAC_ROUND_EN: round half up before the shift; otherwise truncate (floor).
module mac_sat
    import fir_pkg::*;
#(
    parameter int WIDTH_IN  = 20,
    parameter int WIDTH_OUT = 8,
    parameter int SHIFT     = 7
) (
    input  logic signed [WIDTH_IN-1:0]  s,
    output logic signed [WIDTH_OUT-1:0] y,
    output logic                        ovf
);
    // One guard bit so the rounding add can never wrap.
    logic signed [WIDTH_IN:0] s_ext;
    sat_t r;

`ifdef MAC_ROUND_EN
    localparam logic signed [WIDTH_IN:0] HALF =
        (SHIFT > 0) ? ((WIDTH_IN + 1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    assign s_ext = (WIDTH_IN + 1)'(s) + HALF;
`else
    assign s_ext = (WIDTH_IN + 1)'(s);
`endif

    always_comb begin
        r   = sat_shift(SAT_W'(s_ext), SHIFT, WIDTH_OUT);
        y   = WIDTH_OUT'(r.data);
        ovf = r.ovf;
    end

endmodule

// File: rtl/mac_acc.sv
// Pipelined signed MAC: product register, N_TAPS accumulate FSM, then a registered
// shift/saturate output stage. Rounding mode follows MAC_ROUND_EN (see mac_sat).
module mac_acc
    import fir_pkg::*;
#(
    parameter int WIDTH_DATA    = WIDTH_DATA_DEF,
    parameter int WIDTH_COEF    = WIDTH_COEF_DEF,
    parameter int N_TAPS        = 16,
    parameter int WIDTH_ACC     = WIDTH_DATA + WIDTH_COEF + $clog2(N_TAPS),
    parameter int WIDTH_MAC_OUT = 8,
    parameter int SHIFT_OUT     = 7
) (
    input  logic    clk,
    input  logic    reset,
    mac_acc_if.slave bus
);
    localparam int CNT_W = $clog2(N_TAPS + 1);

    logic signed [WIDTH_ACC-1:0]     p_r;
    logic                            v_r;
    logic                            f_r;
    logic signed [WIDTH_ACC-1:0]     acc;
    logic [CNT_W-1:0]                tap_cnt;
    state_t                          state;
    logic signed [WIDTH_ACC-1:0]     fin_s;
    logic                            fin_v;
    logic signed [WIDTH_MAC_OUT-1:0] sat_y;
    logic                            sat_ovf;
    logic signed [WIDTH_MAC_OUT-1:0] dataout_r;
    logic                            out_valid_r;
    logic                            out_ovf_r;

    // Stage 1: operands widened first so the product is exact in WIDTH_ACC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p_r <= '0;
            v_r <= 1'b0;
            f_r <= 1'b0;
        end else begin
            p_r <= WIDTH_ACC'($signed(bus.a)) * WIDTH_ACC'($signed(bus.b));
            v_r <= bus.in_valid;
            f_r <= bus.in_valid & bus.in_first;
        end
    end

    mac_sat #(
        .WIDTH_IN  (WIDTH_ACC),
        .WIDTH_OUT (WIDTH_MAC_OUT),
        .SHIFT     (SHIFT_OUT)
    ) u_sat (
        .s   (fin_s),
        .y   (sat_y),
        .ovf (sat_ovf)
    );

    // Stage 2 (accumulate FSM) and the output register stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            tap_cnt     <= '0;
            fin_s       <= '0;
            fin_v       <= 1'b0;
            dataout_r   <= '0;
            out_valid_r <= 1'b0;
            out_ovf_r   <= 1'b0;
        end else begin
            fin_v       <= 1'b0;
            out_valid_r <= fin_v;
            if (fin_v) begin
                dataout_r <= sat_y;
                out_ovf_r <= sat_ovf;
            end
            if (v_r) begin
                unique case (state)
                    IDLE: begin
                        acc     <= p_r;
                        tap_cnt <= CNT_W'(1);
                        state   <= ACC;
                    end
                    ACC: begin
                        // in_first wins over completion: restart, never emit.
                        if (f_r) begin
                            acc     <= p_r;
                            tap_cnt <= CNT_W'(1);
                        end else if (tap_cnt == CNT_W'(N_TAPS - 1)) begin
                            fin_s   <= acc + p_r;
                            fin_v   <= 1'b1;
                            acc     <= '0;
                            tap_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            acc     <= acc + p_r;
                            tap_cnt <= tap_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dataout   = dataout_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.busy      = (state == ACC);

endmodule

// File: tb/tb_mac_acc.sv
// Three mac_acc builds share one random/directed beat stream; an arithmetic model
// predicts every result, its cycle, the held outputs and busy.
module tb_mac_acc;
    localparam int ND = 3;
    localparam int NT [ND] = '{4, 16, 4};
    localparam int SH [ND] = '{0, 7, 1};

    logic clk;
    logic reset;
    logic in_valid, in_first;
    logic signed [7:0] a, b;

    mac_acc_if bus0 ();
    mac_acc_if bus1 ();
    mac_acc_if bus2 ();

    mac_acc #(.N_TAPS(4),  .SHIFT_OUT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mac_acc #(.N_TAPS(16), .SHIFT_OUT(7)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mac_acc #(.N_TAPS(4),  .SHIFT_OUT(1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus0.in_valid = in_valid; assign bus0.in_first = in_first;
    assign bus0.a = a;               assign bus0.b = b;
    assign bus1.in_valid = in_valid; assign bus1.in_first = in_first;
    assign bus1.a = a;               assign bus1.b = b;
    assign bus2.in_valid = in_valid; assign bus2.in_first = in_first;
    assign bus2.a = a;               assign bus2.b = b;

    logic signed [7:0] dout [ND];
    logic ovld [ND];
    logic ovf  [ND];
    logic bsy  [ND];
    assign dout[0] = bus0.dataout; assign ovld[0] = bus0.out_valid;
    assign ovf[0]  = bus0.out_ovf; assign bsy[0]  = bus0.busy;
    assign dout[1] = bus1.dataout; assign ovld[1] = bus1.out_valid;
    assign ovf[1]  = bus1.out_ovf; assign bsy[1]  = bus1.busy;
    assign dout[2] = bus2.dataout; assign ovld[2] = bus2.out_valid;
    assign ovf[2]  = bus2.out_ovf; assign bsy[2]  = bus2.busy;

    typedef struct { int cyc; int d; bit o; } ev_t;
    ev_t    evq [ND][$];
    longint msum [ND];
    int     mcnt [ND];
    bit     busy_exp [ND];
    int     last_d [ND];
    bit     last_o [ND];
    int     pulses [ND];
    int     cap_d [ND];
    bit     cap_o [ND];
    int     cyc = 0;
    bit     started = 0;
    int     checks = 0;
    int     errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input int d,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %0d expected %0d", nm, d, cyc, act, exp);
        end
    endtask

    // Expected output from the sum: floor (or round-half-up) divide, then clamp.
    function automatic void ref_out(input longint s, input int sh, output int d, output bit o);
        longint div, q;
        div = longint'(1) << sh;
`ifdef MAC_ROUND_EN
        if (sh > 0) s = s + div / 2;
`endif
        q = s / div;
        if (s < 0 && q * div != s) q = q - 1;
        if (q > 127)       begin d = 127;    o = 1'b1; end
        else if (q < -128) begin d = -128;   o = 1'b1; end
        else               begin d = int'(q); o = 1'b0; end
    endfunction

    // Model: consumes the beat seen at each rising edge.
    always @(posedge clk) begin
        longint p;
        int rd;
        bit ro;
        cyc++;
        started = 1'b1;
        for (int d = 0; d < ND; d++) begin
            if (!reset) begin
                while (evq[d].size() > 0 && evq[d][$].cyc >= cyc) void'(evq[d].pop_back());
                msum[d] = 0; mcnt[d] = 0; busy_exp[d] = 1'b0;
                last_d[d] = 0; last_o[d] = 1'b0;
            end else begin
                busy_exp[d] = (mcnt[d] != 0);
                if (in_valid) begin
                    p = longint'(a) * longint'(b);
                    if (mcnt[d] == 0 || in_first) begin
                        msum[d] = p; mcnt[d] = 1;
                    end else begin
                        msum[d] += p; mcnt[d]++;
                        if (mcnt[d] == NT[d]) begin
                            ref_out(msum[d], SH[d], rd, ro);
                            evq[d].push_back('{cyc: cyc + 2, d: rd, o: ro});
                            msum[d] = 0; mcnt[d] = 0;
                        end
                    end
                end
            end
        end
    end

    // Compare process: every cycle, every DUT.
    always @(negedge clk) begin
        bit ev;
        ev_t e;
        if (started) begin
            for (int d = 0; d < ND; d++) begin
                ev = (evq[d].size() > 0) && (evq[d][0].cyc == cyc);
                chk(ovld[d] == ev, "out_valid", d, ovld[d], ev);
                if (ev) begin
                    e = evq[d].pop_front();
                    last_d[d] = e.d; last_o[d] = e.o;
                end
                if (ovld[d]) begin
                    pulses[d]++; cap_d[d] = dout[d]; cap_o[d] = ovf[d];
                end
                chk(int'(dout[d]) == last_d[d], "dataout", d, dout[d], last_d[d]);
                chk(ovf[d] == last_o[d], "out_ovf", d, ovf[d], last_o[d]);
                chk(bsy[d] == busy_exp[d], "busy", d, bsy[d], busy_exp[d]);
            end
        end
    end

    task automatic beat(input int av, input int bv, input bit f);
        @(negedge clk);
        in_valid = 1'b1; in_first = f; a = 8'(av); b = 8'(bv);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; in_first = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in_first = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_caps();
        for (int d = 0; d < ND; d++) begin
            pulses[d] = 0; cap_d[d] = 0; cap_o[d] = 1'b0;
        end
    endtask

    task automatic expect_one(input int d, input int v, input bit o, input string nm);
        chk(pulses[d] == 1, {nm, "_pulses"}, d, pulses[d], 1);
        chk(cap_d[d] == v, {nm, "_data"}, d, cap_d[d], v);
        chk(cap_o[d] == o, {nm, "_ovf"}, d, cap_o[d], o);
    endtask

    initial begin
        int rd;
        bit ro;
        int e_pos, e_neg;
        reset = 1'b0; in_valid = 1'b0; in_first = 1'b0; a = '0; b = '0;
        clear_caps();
        repeat (3) @(negedge clk);
        chk(dout[0] == 0 && ovf[0] == 0, "reset_out", 0, dout[0], 0);
        chk(ovld[1] == 0 && bsy[1] == 0, "reset_ctl", 1, ovld[1], 0);
        reset = 1'b1;

        // Pin the model with hand-computed values.
        ref_out(258064, 7, rd, ro);
        chk(rd == 127 && ro, "model_sat_hi", 1, rd, 127);
        ref_out(-260096, 7, rd, ro);
        chk(rd == -128 && ro, "model_sat_lo", 1, rd, -128);
`ifdef MAC_ROUND_EN
        e_pos = 2; e_neg = -1;
`else
        e_pos = 1; e_neg = -2;
`endif
        ref_out(3, 1, rd, ro);
        chk(rd == e_pos && !ro, "model_shift_pos", 2, rd, e_pos);
        ref_out(-3, 1, rd, ro);
        chk(rd == e_neg && !ro, "model_shift_neg", 2, rd, e_neg);

        // 4 x (3*5) = 60
        clear_caps();
        for (int t = 0; t < 4; t++) beat(3, 5, t == 0);
        idle(5);
        expect_one(0, 60, 1'b0, "basic");
        expect_one(2, 30, 1'b0, "basic_sh1");

        // Full-scale saturation on the default build.
        do_reset(); clear_caps();
        for (int t = 0; t < 16; t++) beat(127, 127, t == 0);
        idle(5);
        expect_one(1, 127, 1'b1, "sat_hi");
        do_reset(); clear_caps();
        for (int t = 0; t < 16; t++) beat(-128, 127, t == 0);
        idle(5);
        expect_one(1, -128, 1'b1, "sat_lo");

        // Shift by one of +3 and -3.
        do_reset(); clear_caps();
        for (int t = 0; t < 4; t++) beat(t < 3 ? 1 : 0, 1, t == 0);
        idle(5);
        expect_one(2, e_pos, 1'b0, "shift_pos");
        clear_caps();
        for (int t = 0; t < 4; t++) beat(t < 3 ? -1 : 0, 1, t == 0);
        idle(5);
        expect_one(2, e_neg, 1'b0, "shift_neg");

        // Abort: two beats, then a fresh in_first sample of four ones.
        do_reset(); clear_caps();
        beat(5, 5, 1'b1); beat(5, 5, 1'b0);
        for (int t = 0; t < 4; t++) beat(1, 1, t == 0);
        idle(5);
        expect_one(0, 4, 1'b0, "abort");

        // Reset mid-sample discards the partial sum.
        do_reset(); clear_caps();
        for (int t = 0; t < 3; t++) beat(7, 7, t == 0);
        do_reset();
        for (int t = 0; t < 4; t++) beat(2, 3, t == 0);
        idle(5);
        expect_one(0, 24, 1'b0, "mid_reset");

        // Same sample with in_valid gaps.
        clear_caps();
        for (int t = 0; t < 4; t++) begin
            beat(2, 3, t == 0);
            idle($urandom_range(1, 3));
        end
        idle(5);
        expect_one(0, 24, 1'b0, "gaps");

        // Three back-to-back samples; spacing is checked cycle-exact by the model.
        clear_caps();
        for (int t = 0; t < 12; t++)
            beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, (t % 4) == 0);
        idle(5);
        chk(pulses[0] == 3, "b2b_pulses", 0, pulses[0], 3);

        // Random traffic with occasional in_first and resets.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 99) < 75);
            in_first = ($urandom_range(0, 99) < 6);
            a        = 8'($urandom_range(0, 255));
            b        = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        reset = 1'b1;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
